pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: WIDTH, default 8, payload width in bits (1..256).
REQ-002 Parameter: BUBBLE, default {WIDTH{1'b0}}, value held in any invalid entry, i.e. the bubble/NOP encoding.
REQ-003 Parameter: CNT_W, default 8, width of the stall counter.
REQ-004 Port: clk  in  1  single clock; all state changes on posedge clk.
REQ-005 Port: reset  in  1  synchronous, active-high; sampled only on posedge clk.
REQ-006 Port: flush  in  1  discard all held entries this cycle.
REQ-007 Port: in_valid  in  1  upstream offers in_data.
REQ-008 Port: in_ready  out  1  stage can accept; driven from registered state only.
REQ-009 Port: in_data  in  WIDTH  upstream payload.
REQ-010 Port: out_valid  out  1  out_data is valid.
REQ-011 Port: out_ready  in  1  downstream accepts out_data.
REQ-012 Port: out_data  out  WIDTH  head entry payload, direct from a register.
REQ-013 Port: occupancy  out  2  number of valid entries (0, 1 or 2).
REQ-014 Port: stall_cnt  out  CNT_W  saturating count of backpressured cycles.

Function
REQ-015 Storage: two WIDTH-bit entries, main (head) and skid; state is one of EMPTY, ONE or FULL.
REQ-016 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-017 Outputs: out_valid = (state != EMPTY); in_ready = (state != FULL); out_data = main; occupancy = 0, 1 or 2 for EMPTY, ONE or FULL.
REQ-018 EMPTY with in_fire: next state ONE; main <= in_data. This gives one-cycle latency from in_fire to out_valid.
REQ-019 EMPTY without in_fire: next state stays EMPTY; entries stay BUBBLE.
REQ-020 ONE with in_fire & out_fire: next state stays ONE; main <= in_data.
REQ-021 ONE with in_fire & !out_fire: next state FULL; skid <= in_data; main is held.
REQ-022 ONE with !in_fire & out_fire: next state EMPTY; main <= BUBBLE.
REQ-023 ONE with neither: all state is held.
REQ-024 FULL with out_fire: next state ONE; main <= skid; skid <= BUBBLE. in_fire cannot occur because in_ready = 0.
REQ-025 FULL without out_fire: all state is held.
REQ-026 Ordering: strict FIFO; no payload is duplicated, reordered or dropped except by flush.
REQ-027 Invalid entries shall always equal BUBBLE, so out_data = BUBBLE whenever out_valid = 0.
REQ-028 flush priority: flush overrides every transfer. Next state is EMPTY; main and skid <= BUBBLE.
REQ-029 flush with a simultaneous in_fire: the incoming payload is discarded.
REQ-030 flush with a simultaneous out_fire: that cycle's out_data counts as delivered.
REQ-031 stall_cnt increments by 1 on every cycle where out_valid & !out_ready & !flush.
REQ-032 stall_cnt saturates at 2^CNT_W-1, never wraps, and is cleared only by reset.
REQ-033 Input data changing while in_valid & !in_ready shall have no effect on stage state.

Reset
REQ-034 When reset = 1 at posedge clk: state <= EMPTY; main and skid <= BUBBLE; stall_cnt <= 0.
REQ-035 Resulting output values after reset: out_valid = 0, in_ready = 1, occupancy = 0, out_data = BUBBLE.
REQ-036 reset overrides flush and all transfers; a payload offered in the reset cycle is lost.
REQ-037 Reset mid-operation (ONE or FULL) shall yield exactly the REQ-034 values one edge later.
REQ-038 No output shall change between clock edges while reset is asserted.

Verification
REQ-039 Streaming: WIDTH=8, out_ready=1, in_data 0x01..0x10 on consecutive cycles -> out_data 0x01..0x10 one cycle later, occupancy never above 1, stall_cnt = 0.
REQ-040 Backpressure: hold 0xA1 in ONE, drop out_ready, offer 0xB2 then 0xC3 -> FULL, in_ready = 0, 0xC3 held upstream; raise out_ready -> outputs 0xA1, 0xB2, 0xC3 in order, stall_cnt equals the number of out_ready = 0 cycles.
REQ-041 Flush race: FULL (0x11, 0x22), assert flush with in_valid = 1 and in_data = 0x33 -> next cycle EMPTY, out_data = BUBBLE, 0x33 never appears at the output.
REQ-042 Saturation: CNT_W=4, out_valid = 1 and out_ready = 0 for 20 cycles -> stall_cnt stops at 15; then flush -> stall_cnt stays 15.
REQ-043 Reset mid-FULL: BUBBLE=8'hFF, entries 0x05 and 0x06, assert reset for 1 cycle -> out_valid = 0, occupancy = 0, out_data = 0xFF, stall_cnt = 0, in_ready = 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with flush and saturating stall counter
module pipe_stage_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] main, skid, main_n, skid_n;
  logic             in_fire, out_fire;
  assign out_valid = state != EMPTY;
  assign in_ready  = state != FULL;
  assign out_data  = main;
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_comb begin
    state_n = flush ? EMPTY
            : state == EMPTY ? (in_fire ? ONE : EMPTY)
            : state == ONE ? (in_fire & !out_fire ? FULL : !in_fire & out_fire ? EMPTY : ONE)
            : (out_fire ? ONE : FULL);
    main_n = flush ? BUBBLE
           : state == FULL ? (out_fire ? skid : main)
           : in_fire & (state == EMPTY | out_fire) ? in_data
           : out_fire ? BUBBLE : main;
    skid_n = flush ? BUBBLE
           : state == FULL ? (out_fire ? BUBBLE : skid)
           : state == ONE & in_fire & !out_fire ? in_data : skid;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main      <= BUBBLE;
      skid      <= BUBBLE;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      main  <= main_n;
      skid  <= skid_n;
      if (out_valid & !out_ready & !flush & stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random scoreboard checks of pipe_stage_reg
module tb_pipe_stage_reg;
  logic       clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;
  int         checks, errors, mcnt;
  logic [7:0] q[$];
  logic [7:0] exp_head;
  pipe_stage_reg #(.WIDTH(8), .BUBBLE(8'hFF), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl, input logic rst);
    logic mi, mo;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != 2));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("out_data", 32'(out_data), 32'(q.size() != 0 ? q[0] : 8'hFF));
    chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; reset = rst;
    mi = iv && q.size() < 2;
    mo = q.size() > 0 && ordy;
    if (!rst && q.size() > 0 && !ordy && !fl && mcnt != 15) mcnt++;
    if (mo) begin
      exp_head = q.pop_front();
      chk("delivered", 32'(out_data), 32'(exp_head));
    end
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else if (fl) q.delete();
    else if (mi) q.push_back(d);
    @(posedge clk);
  endtask
  initial begin
    checks = 0; errors = 0; mcnt = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    step(0, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'hA1, 1, 0, 0);
    step(1, 8'hB2, 0, 0, 0);
    step(1, 8'hC3, 0, 0, 0);
    step(1, 8'hD4, 0, 0, 0);
    step(1, 8'hC3, 1, 0, 0);
    step(1, 8'hC3, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    repeat (20) step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0);
    step(1, 8'h05, 0, 0, 0);
    step(1, 8'h06, 0, 0, 0);
    step(1, 8'h07, 1, 1, 1);
    step(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 1) == 1, 8'($urandom_range(0, 254)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, 0);
    step(0, 8'h00, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
